ddr_axi_responder: RTL and testbench

Single-clock responder for the Pango DDR AXI-style user port: it accepts write and read address requests from a DDR bridge master, sinks write beats into an internal register-array memory, and returns read bursts after a fixed latency. It stands in for the DDR controller IP in simulation and FPGA bring-up, sitting directly on the bridge's axi_* port with no controller or PHY.

---
 rtl/ddr_axi_responder_if.sv | 48 ++++
 rtl/ddr_axi_responder.sv | 134 +++++++++++++
 tb/tb_ddr_axi_responder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_axi_responder_if.sv
// Bundle of the DDR bridge user-port signals seen by the responder.
// The master is the DDR bridge; the slave is the responder model.
interface ddr_axi_responder_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 256
);
  logic [ADDR_W-1:0]   axi_awaddr;
  logic                axi_awuser_ap;
  logic [3:0]          axi_awuser_id;
  logic [3:0]          axi_awlen;
  logic                axi_awvalid;
  logic                axi_awready;
  logic [DATA_W-1:0]   axi_wdata;
  logic [DATA_W/8-1:0] axi_wstrb;
  logic                axi_wready;
  logic [3:0]          axi_wusero_id;
  logic                axi_wusero_last;
  logic [ADDR_W-1:0]   axi_araddr;
  logic                axi_aruser_ap;
  logic [3:0]          axi_aruser_id;
  logic [3:0]          axi_arlen;
  logic                axi_arvalid;
  logic                axi_arready;
  logic [DATA_W-1:0]   axi_rdata;
  logic [3:0]          axi_rid;
  logic                axi_rlast;
  logic                axi_rvalid;

  modport master (
    output axi_awaddr, axi_awuser_ap, axi_awuser_id, axi_awlen, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb,
    input  axi_wready, axi_wusero_id, axi_wusero_last,
    output axi_araddr, axi_aruser_ap, axi_aruser_id, axi_arlen, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rid, axi_rlast, axi_rvalid
  );

  modport slave (
    input  axi_awaddr, axi_awuser_ap, axi_awuser_id, axi_awlen, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb,
    output axi_wready, axi_wusero_id, axi_wusero_last,
    input  axi_araddr, axi_aruser_ap, axi_aruser_id, axi_arlen, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rid, axi_rlast, axi_rvalid
  );
endinterface

// File: rtl/ddr_axi_responder.sv
// Stand-in for the DDR controller on the bridge's user port: one burst at a
// time, writes sink into a beat-wide memory, reads return after RD_LAT+1
// cycles. Memory is deliberately not reset so contents survive rst_n.
module ddr_axi_responder #(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 256,
  parameter int DEPTH_LOG2 = 6,
  parameter int ADDR_LSB   = 3,
  parameter int RD_LAT     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ddr_axi_responder_if.slave   bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WDATA, RWAIT, RDATA} state_t;

  state_t                  state_reg;
  logic [DEPTH_LOG2-1:0]   idx_reg;
  logic [3:0]              len_reg;
  logic [3:0]              id_reg;
  logic [3:0]              cnt_reg;
  logic                    rvalid_reg;
  logic                    rlast_reg;
  logic [3:0]              rid_reg;
  logic [DATA_W-1:0]       rdata_reg;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DATA_W-1:0]       wr_word;

  // Address bits outside the beat index and the precharge hints are ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.axi_awuser_ap, bus.axi_aruser_ap,
                         bus.axi_awaddr[ADDR_W-1:ADDR_LSB+DEPTH_LOG2],
                         bus.axi_awaddr[ADDR_LSB-1:0],
                         bus.axi_araddr[ADDR_W-1:ADDR_LSB+DEPTH_LOG2],
                         bus.axi_araddr[ADDR_LSB-1:0]};

  // Handshake and write-side outputs decode directly from registered state.
  assign bus.axi_awready     = (state_reg == IDLE);
  assign bus.axi_arready     = (state_reg == IDLE) && !bus.axi_awvalid;
  assign bus.axi_wready      = (state_reg == WDATA);
  assign bus.axi_wusero_last = (state_reg == WDATA) && (cnt_reg == len_reg);
  assign bus.axi_wusero_id   = (state_reg == WDATA) ? id_reg : 4'd0;

  assign bus.axi_rvalid = rvalid_reg;
  assign bus.axi_rlast  = rlast_reg;
  assign bus.axi_rid    = rid_reg;
  assign bus.axi_rdata  = rdata_reg;

  // Byte-lane merge: unstrobed lanes keep the stored byte.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      assign wr_word[gi*8 +: 8] = bus.axi_wstrb[gi] ? bus.axi_wdata[gi*8 +: 8]
                                                    : mem[idx_reg][gi*8 +: 8];
    end
  endgenerate

  // Memory write port; no reset so contents persist across rst_n.
  always_ff @(posedge clk) begin
    if (state_reg == WDATA) begin
      mem[idx_reg] <= wr_word;
    end
  end

  // Burst sequencer with registered read-data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      len_reg    <= '0;
      id_reg     <= '0;
      cnt_reg    <= '0;
      rvalid_reg <= 1'b0;
      rlast_reg  <= 1'b0;
      rid_reg    <= '0;
      rdata_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (bus.axi_awvalid) begin
            idx_reg   <= bus.axi_awaddr[ADDR_LSB +: DEPTH_LOG2];
            len_reg   <= bus.axi_awlen;
            id_reg    <= bus.axi_awuser_id;
            state_reg <= WDATA;
          end else if (bus.axi_arvalid) begin
            idx_reg   <= bus.axi_araddr[ADDR_LSB +: DEPTH_LOG2];
            len_reg   <= bus.axi_arlen;
            id_reg    <= bus.axi_aruser_id;
            state_reg <= RWAIT;
          end
        end
        WDATA: begin
          idx_reg <= idx_reg + 1'b1;
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == len_reg) begin
            state_reg <= IDLE;
          end
        end
        RWAIT: begin
          if (cnt_reg == 4'(RD_LAT - 1)) begin
            state_reg  <= RDATA;
            rvalid_reg <= 1'b1;
            rdata_reg  <= mem[idx_reg];
            rid_reg    <= id_reg;
            rlast_reg  <= (len_reg == 4'd0);
            idx_reg    <= idx_reg + 1'b1;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        RDATA: begin
          if (rlast_reg) begin
            state_reg  <= IDLE;
            rvalid_reg <= 1'b0;
            rlast_reg  <= 1'b0;
            rid_reg    <= '0;
            rdata_reg  <= '0;
          end else begin
            rdata_reg <= mem[idx_reg];
            idx_reg   <= idx_reg + 1'b1;
            cnt_reg   <= cnt_reg + 4'd1;
            rlast_reg <= ((cnt_reg + 4'd1) == len_reg);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_axi_responder.sv
// Bench for ddr_axi_responder: directed cases plus randomized bursts checked
// against a byte-wise reference memory. Three instances share the stimulus
// so read latency can be measured for RD_LAT = 4, 1 and 15.
module tb_ddr_axi_responder;
  localparam int MAIN_LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [27:0]  awaddr = '0, araddr = '0;
  logic [3:0]   awlen = '0, awid = '0, arlen = '0, arid = '0;
  logic         awvalid = 1'b0, arvalid = 1'b0;
  logic [255:0] wdata = '0;
  logic [31:0]  wstrb = '0;

  logic         awready, arready, wready, wlast, rvalid, rlast;
  logic [3:0]   wid, rid;
  logic [255:0] rdata;
  logic [2:0]   rv;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      ddr_axi_responder_if #(.ADDR_W(28), .DATA_W(256)) bus ();
      assign bus.axi_awaddr    = awaddr;
      assign bus.axi_awuser_ap = 1'b0;
      assign bus.axi_awuser_id = awid;
      assign bus.axi_awlen     = awlen;
      assign bus.axi_awvalid   = awvalid;
      assign bus.axi_wdata     = wdata;
      assign bus.axi_wstrb     = wstrb;
      assign bus.axi_araddr    = araddr;
      assign bus.axi_aruser_ap = 1'b0;
      assign bus.axi_aruser_id = arid;
      assign bus.axi_arlen     = arlen;
      assign bus.axi_arvalid   = arvalid;
      assign rv[gi]            = bus.axi_rvalid;
      ddr_axi_responder #(
        .ADDR_W(28), .DATA_W(256), .DEPTH_LOG2(6), .ADDR_LSB(3),
        .RD_LAT((gi == 0) ? 4 : (gi == 1) ? 1 : 15)
      ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
      );
      if (gi == 0) begin : g_main
        assign awready = bus.axi_awready;
        assign arready = bus.axi_arready;
        assign wready  = bus.axi_wready;
        assign wlast   = bus.axi_wusero_last;
        assign wid     = bus.axi_wusero_id;
        assign rvalid  = bus.axi_rvalid;
        assign rlast   = bus.axi_rlast;
        assign rid     = bus.axi_rid;
        assign rdata   = bus.axi_rdata;
      end
    end
  endgenerate

  int total = 0;
  int bad   = 0;

  // Reference memory: one 256-bit word per beat index.
  logic [255:0] ref_mem [64];
  logic [255:0] wbeat [16];
  logic [31:0]  wstrbs [16];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int beat_idx(input logic [27:0] addr);
    return int'(addr[8:3]);
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Write burst; beats come from wbeat/wstrbs. Starts and ends at a negedge.
  task automatic do_write(input logic [27:0] addr, input logic [3:0] len, input logic [3:0] id);
    int n = 0;
    int i = beat_idx(addr);
    awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
    #1;
    while (!awready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("aw_ready", awready, 1'b1);
    chk("ar_blocked_by_aw", arready, 1'b0);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    awlen = ~len;
    wdata = wbeat[0]; wstrb = wstrbs[0];
    for (int b = 0; b <= int'(len); b++) begin
      @(negedge clk);
      chk("wready", wready, 1'b1);
      chk("wlast", wlast, (b == int'(len)));
      chk("wid", wid, id);
      chk("awready_busy", awready, 1'b0);
      chk("arready_busy", arready, 1'b0);
      @(posedge clk);
      for (int k = 0; k < 32; k++)
        if (wstrbs[b][k]) ref_mem[(i + b) % 64][k*8 +: 8] = wbeat[b][k*8 +: 8];
      #1;
      if (b < int'(len)) begin
        wdata = wbeat[b+1]; wstrb = wstrbs[b+1];
      end
    end
    @(negedge clk);
    chk("wready_end", wready, 1'b0);
    chk("wid_end", wid, 4'd0);
    chk("awready_end", awready, 1'b1);
    $display("write addr=%h idx=%0d len=%0d id=%0d", addr, i, len, id);
  endtask

  // Read burst checked beat by beat against ref_mem. Starts and ends at a negedge.
  task automatic do_read(input logic [27:0] addr, input logic [3:0] len, input logic [3:0] id,
                         output int waited);
    int n = 0;
    int i = beat_idx(addr);
    araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
    #1;
    while (!arready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    waited = n;
    chk("ar_ready", arready, 1'b1);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    arlen = ~len;
    for (int k = 1; k <= MAIN_LAT; k++) begin
      @(negedge clk);
      chk("rd_wait", rvalid, 1'b0);
    end
    for (int b = 0; b <= int'(len); b++) begin
      @(negedge clk);
      chk("rvalid", rvalid, 1'b1);
      chk("rdata", rdata, ref_mem[(i + b) % 64]);
      chk("rid", rid, id);
      chk("rlast", rlast, (b == int'(len)));
    end
    @(negedge clk);
    chk("rvalid_end", rvalid, 1'b0);
    chk("arready_end", arready, 1'b1);
    $display("read  addr=%h idx=%0d len=%0d id=%0d", addr, i, len, id);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, awready, 1'b1);
    chk({tag, "_arready"}, arready, 1'b1);
    chk({tag, "_wready"}, wready, 1'b0);
    chk({tag, "_wlast"}, wlast, 1'b0);
    chk({tag, "_wid"}, wid, 4'd0);
    chk({tag, "_rvalid"}, rvalid, 1'b0);
    chk({tag, "_rlast"}, rlast, 1'b0);
    chk({tag, "_rid"}, rid, 4'd0);
    chk({tag, "_rdata"}, rdata, 256'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int first [3];
    logic [27:0] a;
    logic [3:0] l;

    // Reset held for 3 cycles.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    $display("reset released");

    // Read latency on all three instances (data content not yet defined).
    araddr = '0; arlen = 4'd0; arid = 4'd0; arvalid = 1'b1;
    #1;
    chk("sweep_arready", arready, 1'b1);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    for (int d = 0; d < 3; d++) first[d] = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        if (first[d] == 0 && rv[d]) first[d] = k;
    end
    chk("lat4_first", 32'(first[0]), 32'd5);
    chk("lat1_first", 32'(first[1]), 32'd2);
    chk("lat15_first", 32'(first[2]), 32'd16);
    $display("latency sweep first_rvalid=%0d,%0d,%0d", first[0], first[1], first[2]);

    // Single-beat write/read.
    wbeat[0] = {32{8'hA5}}; wstrbs[0] = 32'hFFFF_FFFF;
    do_write(28'h8, 4'd0, 4'd5);
    do_read(28'h8, 4'd0, 4'd3, w);
    chk("single_rdata_const", ref_mem[1], {32{8'hA5}});

    // Partial strobe over idx 1.
    wbeat[0] = {32{8'h11}}; wstrbs[0] = 32'h0000_000F;
    do_write(28'h8, 4'd0, 4'd1);
    do_read(28'h8, 4'd0, 4'd2, w);

    // Wrapping burst 62, 63, 0, 1.
    for (int b = 0; b < 4; b++) begin
      wbeat[b] = {32{8'hD0 + 8'(b)}}; wstrbs[b] = 32'hFFFF_FFFF;
    end
    do_write(28'(62 << 3), 4'd3, 4'd6);
    do_read(28'(62 << 3), 4'd3, 4'd4, w);

    // Simultaneous AW and AR: write wins, read follows right after.
    araddr = 28'h10; arlen = 4'd1; arid = 4'd9; arvalid = 1'b1;
    wbeat[0] = rand256(); wbeat[1] = rand256();
    wstrbs[0] = 32'hFFFF_FFFF; wstrbs[1] = 32'hFFFF_FFFF;
    do_write(28'h10, 4'd1, 4'd7);
    chk("arb_arready_after", arready, 1'b1);
    do_read(28'h10, 4'd1, 4'd9, w);
    chk("arb_read_wait", 32'(w), 32'd0);

    // Fill the whole memory so every later read has a defined model value.
    for (int j = 0; j < 4; j++) begin
      for (int b = 0; b < 16; b++) begin
        wbeat[b] = rand256(); wstrbs[b] = 32'hFFFF_FFFF;
      end
      do_write(28'(j * 16 << 3), 4'd15, 4'(j));
    end

    // Randomized bursts with aliasing addresses and random strobes.
    for (int t = 0; t < 40; t++) begin
      a = 28'($urandom);
      l = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < 16; b++) begin
          wbeat[b] = rand256();
          wstrbs[b] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
        do_write(a, l, 4'($urandom));
      end else begin
        do_read(a, l, 4'($urandom), w);
      end
    end

    // Reset in the middle of a read burst.
    araddr = 28'(5 << 3); arlen = 4'd7; arid = 4'd2; arvalid = 1'b1;
    #1;
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    repeat (MAIN_LAT + 1) @(negedge clk);
    chk("midrd_rvalid_before", rvalid, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrd");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("mid-burst reset applied");

    // Memory survives reset.
    do_read(28'(5 << 3), 4'd7, 4'd2, w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
